// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting ports (instruction and data),
// the arbiter and the backing memory. The master view belongs to the
// arbiter, which drives the memory and answers both ports. The slave
// view belongs to the environment: the requesters and the memory model.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   // instruction port
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_read_en;
   logic [DATA_WIDTH-1:0] i_read_val;
   logic                  i_response;
   // data port
   logic [ADDR_WIDTH-1:0] d_addr;
   logic                  d_read_en;
   logic                  d_write_en;
   logic [DATA_WIDTH-1:0] d_write_val;
   logic [DATA_WIDTH-1:0] d_read_val;
   logic                  d_response;
   // backing memory
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_read_en;
   logic                  mem_write_en;
   logic [DATA_WIDTH-1:0] mem_write_val;
   logic [DATA_WIDTH-1:0] mem_read_val;
   logic                  mem_ready;
   // status
   logic                  bus_err;

   modport master (
      input  i_addr, i_read_en, d_addr, d_read_en, d_write_en, d_write_val,
             mem_read_val, mem_ready,
      output i_read_val, i_response, d_read_val, d_response,
             mem_addr, mem_read_en, mem_write_en, mem_write_val, bus_err
   );

   modport slave (
      output i_addr, i_read_en, d_addr, d_read_en, d_write_en, d_write_val,
             mem_read_val, mem_ready,
      input  i_read_val, i_response, d_read_val, d_response,
             mem_addr, mem_read_en, mem_write_en, mem_write_val, bus_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single backing memory.
// One access is in flight at a time: IDLE grants, ISSUE holds the memory
// strobe until mem_ready or a timeout, RESP pulses the winner's response.
// Every output is a flop; the only combinational logic is the grant pick.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus
);

   // Counter only has to reach TIMEOUT-1; the timeout fires on the edge
   // that would have taken it to TIMEOUT.
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0] ERR_VAL = DATA_WIDTH'({(DATA_WIDTH/4){4'hE}});

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state;
   logic             gnt_d;     // 1: data port owns the current access
   logic             is_write;  // current access is a write
   logic             prio_d;    // 1: data port wins the next tie
   logic [CNT_W-1:0] cnt;

   logic want_i;
   logic want_d;
   logic pick_d;

   // Request decode and round-robin tie break.
   always_comb begin
      want_i = bus.i_read_en;
      want_d = bus.d_read_en | bus.d_write_en;
      pick_d = want_d & (~want_i | prio_d);
   end

   // Arbiter FSM with all outputs registered; reset aborts any access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         gnt_d             <= 1'b0;
         is_write          <= 1'b0;
         prio_d            <= 1'b1;
         cnt               <= '0;
         bus.mem_addr      <= '0;
         bus.mem_write_val <= '0;
         bus.mem_read_en   <= 1'b0;
         bus.mem_write_en  <= 1'b0;
         bus.i_read_val    <= '0;
         bus.d_read_val    <= '0;
         bus.i_response    <= 1'b0;
         bus.d_response    <= 1'b0;
         bus.bus_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (want_i | want_d) begin
                  state  <= ISSUE;
                  cnt    <= '0;
                  gnt_d  <= pick_d;
                  prio_d <= ~pick_d;
                  if (pick_d) begin
                     // write wins when both data strobes are up
                     bus.mem_addr      <= bus.d_addr;
                     bus.mem_write_val <= bus.d_write_val;
                     bus.mem_write_en  <= bus.d_write_en;
                     bus.mem_read_en   <= ~bus.d_write_en;
                     is_write          <= bus.d_write_en;
                  end else begin
                     bus.mem_addr     <= bus.i_addr;
                     bus.mem_write_en <= 1'b0;
                     bus.mem_read_en  <= 1'b1;
                     is_write         <= 1'b0;
                  end
               end
            end

            ISSUE: begin
               if (bus.mem_ready || cnt == CNT_LAST) begin
                  state            <= RESP;
                  bus.mem_read_en  <= 1'b0;
                  bus.mem_write_en <= 1'b0;
                  if (gnt_d) bus.d_response <= 1'b1;
                  else       bus.i_response <= 1'b1;
                  if (!bus.mem_ready) bus.bus_err <= 1'b1;
                  if (!is_write) begin
                     if (gnt_d) bus.d_read_val <= bus.mem_ready ? bus.mem_read_val : ERR_VAL;
                     else       bus.i_read_val <= bus.mem_ready ? bus.mem_read_val : ERR_VAL;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RESP: begin
               state          <= IDLE;
               bus.i_response <= 1'b0;
               bus.d_response <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs are driven and outputs sampled on
// the falling edge, so each @(negedge clk) advances exactly one rising edge.
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   tests_run = 0;
   int   tests_failed = 0;

   mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.i_addr = '0; bus.i_read_en = 1'b0;
      bus.d_addr = '0; bus.d_read_en = 1'b0; bus.d_write_en = 1'b0; bus.d_write_val = '0;
      bus.mem_read_val = '0; bus.mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      do_reset();
      tests_run++; if (bus.mem_read_en !== 1'b0) begin tests_failed++; $display("FAIL rst_rd_en: got %0b want 0", bus.mem_read_en); end
      tests_run++; if (bus.mem_write_en !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_en: got %0b want 0", bus.mem_write_en); end
      tests_run++; if (bus.i_response !== 1'b0) begin tests_failed++; $display("FAIL rst_i_resp: got %0b want 0", bus.i_response); end
      tests_run++; if (bus.d_response !== 1'b0) begin tests_failed++; $display("FAIL rst_d_resp: got %0b want 0", bus.d_response); end
      tests_run++; if (bus.bus_err !== 1'b0) begin tests_failed++; $display("FAIL rst_bus_err: got %0b want 0", bus.bus_err); end
      tests_run++; if (bus.i_read_val !== 32'h0) begin tests_failed++; $display("FAIL rst_i_val: got %h want 0", bus.i_read_val); end
      tests_run++; if (bus.d_read_val !== 32'h0) begin tests_failed++; $display("FAIL rst_d_val: got %h want 0", bus.d_read_val); end
      tests_run++; if (bus.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
      tests_run++; if (bus.mem_write_val !== 32'h0) begin tests_failed++; $display("FAIL rst_wval: got %h want 0", bus.mem_write_val); end
      @(negedge clk);
      tests_run++; if (bus.mem_read_en !== 1'b0) begin tests_failed++; $display("FAIL idle_rd_en: got %0b want 0", bus.mem_read_en); end
   endtask

   task automatic test_single_read();
      bus.i_addr = 32'h10; bus.i_read_en = 1'b1; bus.mem_read_val = 32'h12345678;
      @(negedge clk);
      tests_run++; if (bus.mem_read_en !== 1'b1) begin tests_failed++; $display("FAIL sr_rd_en: got %0b want 1", bus.mem_read_en); end
      tests_run++; if (bus.mem_write_en !== 1'b0) begin tests_failed++; $display("FAIL sr_wr_en: got %0b want 0", bus.mem_write_en); end
      tests_run++; if (bus.mem_addr !== 32'h10) begin tests_failed++; $display("FAIL sr_addr: got %h want 10", bus.mem_addr); end
      tests_run++; if (bus.i_response !== 1'b0) begin tests_failed++; $display("FAIL sr_early_resp: got %0b want 0", bus.i_response); end
      bus.i_read_en = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.mem_read_en !== 1'b0) begin tests_failed++; $display("FAIL sr_rd_drop: got %0b want 0", bus.mem_read_en); end
      tests_run++; if (bus.i_response !== 1'b1) begin tests_failed++; $display("FAIL sr_i_resp: got %0b want 1", bus.i_response); end
      tests_run++; if (bus.d_response !== 1'b0) begin tests_failed++; $display("FAIL sr_d_resp: got %0b want 0", bus.d_response); end
      tests_run++; if (bus.i_read_val !== 32'h12345678) begin tests_failed++; $display("FAIL sr_i_val: got %h want 12345678", bus.i_read_val); end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      tests_run++; if (bus.i_response !== 1'b0) begin tests_failed++; $display("FAIL sr_resp_width: got %0b want 0", bus.i_response); end
   endtask

   task automatic test_priority_after_reset();
      do_reset();
      bus.i_addr = 32'h40; bus.i_read_en = 1'b1;
      bus.d_addr = 32'h20; bus.d_write_en = 1'b1; bus.d_write_val = 32'hCAFEF00D;
      bus.mem_read_val = 32'hA5A50001;
      @(negedge clk);
      tests_run++; if (bus.mem_write_en !== 1'b1) begin tests_failed++; $display("FAIL pr_wr_en: got %0b want 1", bus.mem_write_en); end
      tests_run++; if (bus.mem_read_en !== 1'b0) begin tests_failed++; $display("FAIL pr_rd_en: got %0b want 0", bus.mem_read_en); end
      tests_run++; if (bus.mem_addr !== 32'h20) begin tests_failed++; $display("FAIL pr_addr: got %h want 20", bus.mem_addr); end
      tests_run++; if (bus.mem_write_val !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL pr_wval: got %h want cafef00d", bus.mem_write_val); end
      bus.d_write_en = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.d_response !== 1'b1) begin tests_failed++; $display("FAIL pr_d_resp: got %0b want 1", bus.d_response); end
      tests_run++; if (bus.i_response !== 1'b0) begin tests_failed++; $display("FAIL pr_i_quiet: got %0b want 0", bus.i_response); end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      tests_run++; if (bus.mem_read_en !== 1'b0) begin tests_failed++; $display("FAIL pr_resp_ignores_req: got %0b want 0", bus.mem_read_en); end
      tests_run++; if (bus.d_response !== 1'b0) begin tests_failed++; $display("FAIL pr_d_resp_width: got %0b want 0", bus.d_response); end
      @(negedge clk);
      tests_run++; if (bus.mem_read_en !== 1'b1) begin tests_failed++; $display("FAIL pr_i_grant: got %0b want 1", bus.mem_read_en); end
      tests_run++; if (bus.mem_addr !== 32'h40) begin tests_failed++; $display("FAIL pr_i_addr: got %h want 40", bus.mem_addr); end
      bus.i_read_en = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.i_response !== 1'b1) begin tests_failed++; $display("FAIL pr_i_resp: got %0b want 1", bus.i_response); end
      tests_run++; if (bus.d_response !== 1'b0) begin tests_failed++; $display("FAIL pr_d_quiet: got %0b want 0", bus.d_response); end
      tests_run++; if (bus.i_read_val !== 32'hA5A50001) begin tests_failed++; $display("FAIL pr_i_val: got %h want a5a50001", bus.i_read_val); end
      bus.mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_i;
      logic [31:0] exp_d;
      logic        want_d;
      logic [31:0] val;
      int          waited;
      do_reset();
      exp_i = 32'h0; exp_d = 32'h0;
      bus.d_read_en = 1'b1; bus.d_addr = 32'h300;
      bus.i_read_en = 1'b1; bus.i_addr = 32'h100;
      for (int t = 0; t < 4; t++) begin
         want_d = (t % 2 == 0);
         waited = 0;
         @(negedge clk);
         while (bus.mem_read_en !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
         end
         tests_run++; if (waited >= 8) begin tests_failed++; $display("FAIL rr_strobe_t%0d: got none want strobe within 8 cycles", t); end
         tests_run++; if (bus.mem_addr !== (want_d ? 32'h300 : 32'h100)) begin tests_failed++; $display("FAIL rr_grant_t%0d: got addr %h want %h", t, bus.mem_addr, (want_d ? 32'h300 : 32'h100)); end
         val = 32'hB0000000 + 32'(t);
         if (want_d) exp_d = val; else exp_i = val;
         bus.mem_read_val = val; bus.mem_ready = 1'b1;
         @(negedge clk);
         tests_run++; if (bus.d_response !== want_d) begin tests_failed++; $display("FAIL rr_d_resp_t%0d: got %0b want %0b", t, bus.d_response, want_d); end
         tests_run++; if (bus.i_response !== ~want_d) begin tests_failed++; $display("FAIL rr_i_resp_t%0d: got %0b want %0b", t, bus.i_response, ~want_d); end
         tests_run++; if (bus.d_read_val !== exp_d) begin tests_failed++; $display("FAIL rr_d_val_t%0d: got %h want %h", t, bus.d_read_val, exp_d); end
         tests_run++; if (bus.i_read_val !== exp_i) begin tests_failed++; $display("FAIL rr_i_val_t%0d: got %h want %h", t, bus.i_read_val, exp_i); end
         bus.mem_ready = 1'b0;
      end
      bus.d_read_en = 1'b0; bus.i_read_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      bus.d_read_en = 1'b1; bus.d_addr = 32'h50; bus.mem_ready = 1'b0;
      @(negedge clk);
      bus.d_read_en = 1'b0;
      n = 0;
      while (bus.mem_read_en === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      tests_run++; if (n != 4) begin tests_failed++; $display("FAIL to_strobe_cycles: got %0d want 4", n); end
      tests_run++; if (bus.d_response !== 1'b1) begin tests_failed++; $display("FAIL to_d_resp: got %0b want 1", bus.d_response); end
      tests_run++; if (bus.i_response !== 1'b0) begin tests_failed++; $display("FAIL to_i_quiet: got %0b want 0", bus.i_response); end
      tests_run++; if (bus.d_read_val !== 32'hEEEEEEEE) begin tests_failed++; $display("FAIL to_d_val: got %h want eeeeeeee", bus.d_read_val); end
      tests_run++; if (bus.bus_err !== 1'b1) begin tests_failed++; $display("FAIL to_bus_err: got %0b want 1", bus.bus_err); end
      @(negedge clk);
      tests_run++; if (bus.d_response !== 1'b0) begin tests_failed++; $display("FAIL to_resp_width: got %0b want 0", bus.d_response); end
      bus.i_read_en = 1'b1; bus.i_addr = 32'h60; bus.mem_read_val = 32'h0F0F0F0F;
      @(negedge clk);
      bus.i_read_en = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.i_read_val !== 32'h0F0F0F0F) begin tests_failed++; $display("FAIL to_next_i_val: got %h want 0f0f0f0f", bus.i_read_val); end
      tests_run++; if (bus.bus_err !== 1'b1) begin tests_failed++; $display("FAIL to_err_sticky: got %0b want 1", bus.bus_err); end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      do_reset();
      tests_run++; if (bus.bus_err !== 1'b0) begin tests_failed++; $display("FAIL to_err_clear: got %0b want 0", bus.bus_err); end
   endtask

   task automatic test_reset_mid_issue();
      bus.i_read_en = 1'b1; bus.i_addr = 32'h70; bus.mem_ready = 1'b0;
      @(negedge clk);
      tests_run++; if (bus.mem_read_en !== 1'b1) begin tests_failed++; $display("FAIL rm_issue: got %0b want 1", bus.mem_read_en); end
      reset = 1'b1; bus.i_read_en = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.mem_read_en !== 1'b0) begin tests_failed++; $display("FAIL rm_rd_en: got %0b want 0", bus.mem_read_en); end
      tests_run++; if (bus.i_response !== 1'b0) begin tests_failed++; $display("FAIL rm_i_resp: got %0b want 0", bus.i_response); end
      reset = 1'b0;
      @(negedge clk);
      tests_run++; if (bus.i_response !== 1'b0) begin tests_failed++; $display("FAIL rm_no_late_resp: got %0b want 0", bus.i_response); end
      bus.mem_ready = 1'b0;
      bus.d_read_en = 1'b1; bus.d_addr = 32'h80; bus.mem_read_val = 32'h55AA33CC;
      @(negedge clk);
      tests_run++; if (bus.mem_addr !== 32'h80 || bus.mem_read_en !== 1'b1) begin tests_failed++; $display("FAIL rm_new_grant: got addr %h rd %0b want 80 1", bus.mem_addr, bus.mem_read_en); end
      bus.d_read_en = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.d_response !== 1'b1) begin tests_failed++; $display("FAIL rm_new_resp: got %0b want 1", bus.d_response); end
      tests_run++; if (bus.d_read_val !== 32'h55AA33CC) begin tests_failed++; $display("FAIL rm_new_val: got %h want 55aa33cc", bus.d_read_val); end
      bus.mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_write_both();
      bus.d_read_en = 1'b1; bus.d_write_en = 1'b1; bus.d_addr = 32'h90;
      bus.d_write_val = 32'h01020304; bus.mem_read_val = 32'hDEADBEEF;
      @(negedge clk);
      tests_run++; if (bus.mem_write_en !== 1'b1) begin tests_failed++; $display("FAIL rw_wr_en: got %0b want 1", bus.mem_write_en); end
      tests_run++; if (bus.mem_read_en !== 1'b0) begin tests_failed++; $display("FAIL rw_rd_en: got %0b want 0", bus.mem_read_en); end
      tests_run++; if (bus.mem_write_val !== 32'h01020304) begin tests_failed++; $display("FAIL rw_wval: got %h want 01020304", bus.mem_write_val); end
      bus.d_read_en = 1'b0; bus.d_write_en = 1'b0;
      @(negedge clk);
      tests_run++; if (bus.mem_write_en !== 1'b1) begin tests_failed++; $display("FAIL rw_hold: got %0b want 1", bus.mem_write_en); end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.d_response !== 1'b1) begin tests_failed++; $display("FAIL rw_resp: got %0b want 1", bus.d_response); end
      tests_run++; if (bus.d_read_val !== 32'h55AA33CC) begin tests_failed++; $display("FAIL rw_d_val_kept: got %h want 55aa33cc", bus.d_read_val); end
      bus.mem_ready = 1'b0;
      @(negedge clk);
   endtask

   // directed test sequence
   initial begin
      test_reset();
      test_single_read();
      test_priority_after_reset();
      test_round_robin();
      test_timeout();
      test_reset_mid_issue();
      test_read_write_both();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // run-length guard
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000 time units");
      $fatal(1);
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, width of every data bus.
- ADDR_WIDTH, 32, width of every address bus.
- TIMEOUT, 255, maximum number of ISSUE cycles to wait for mem_ready; must be at least 1.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is on the rising edge.
- reset, in, 1, synchronous, active-high.
- i_addr, in, ADDR_WIDTH, instruction-port address.
- i_read_en, in, 1, instruction-port read request, level-held.
- i_read_val, out, DATA_WIDTH, instruction-port read data.
- i_response, out, 1, instruction-port completion, one-cycle pulse.
- d_addr, in, ADDR_WIDTH, data-port address.
- d_read_en, in, 1, data-port read request, level-held.
- d_write_en, in, 1, data-port write request, level-held.
- d_write_val, in, DATA_WIDTH, data-port write data.
- d_read_val, out, DATA_WIDTH, data-port read data.
- d_response, out, 1, data-port completion, one-cycle pulse.
- mem_addr, out, ADDR_WIDTH, backing-memory address.
- mem_read_en, out, 1, backing-memory read strobe.
- mem_write_en, out, 1, backing-memory write strobe.
- mem_write_val, out, DATA_WIDTH, backing-memory write data.
- mem_read_val, in, DATA_WIDTH, backing-memory read data.
- mem_ready, in, 1, backing memory has completed the current access.
- bus_err, out, 1, sticky flag: a timeout has occurred.

REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high on port reset.

Function
REQ-004 Every output shall be a register; the block shall have no combinational path from input to output.
REQ-005 The state machine shall have exactly three states: IDLE, ISSUE and RESP.
REQ-006 In IDLE, a pending request (i_read_en, or d_read_en|d_write_en) shall be granted at the clock edge: the addressed data is latched, state moves to ISSUE and the timeout counter clears.
REQ-007 When both ports request in the same IDLE cycle, the arbiter shall grant the port not granted last time (round-robin); after reset the data port has priority.
REQ-008 If d_read_en and d_write_en are both high, the access shall be a write; a read shall not also be performed.
REQ-009 In ISSUE, mem_addr and mem_write_val shall be held stable, and exactly one of mem_read_en/mem_write_en shall be high for every ISSUE cycle.
REQ-010 On the first edge where mem_ready=1 in ISSUE:
- for a read, mem_read_val is captured into the granted port's read_val;
- the strobes drop;
- state moves to RESP.
REQ-011 In RESP, the granted port's response shall be 1 for exactly one cycle; state then returns to IDLE, and requests are ignored during RESP.
REQ-012 Minimum latency: request sampled at edge k, mem strobe high during cycle k+1, mem_ready sampled at edge k+1, response high during cycle k+2.
REQ-013 The read_val of the ungranted port shall be left unchanged; read_val shall be held until that port's next read completes.
REQ-014 The timeout counter shall increment every ISSUE cycle without mem_ready. On reaching TIMEOUT:
- strobes drop;
- for a read, the granted read_val is set to {DATA_WIDTH/4{4'hE}};
- bus_err is set;
- state moves to RESP.
REQ-015 bus_err shall clear only on reset.
REQ-016 mem_ready is ignored outside ISSUE.
REQ-017 A request withdrawn during ISSUE shall not abort the access, which shall complete normally.
REQ-018 i_response and d_response shall never be high in the same cycle.

Reset
REQ-019 While reset=1, on the next edge: state=IDLE, all strobes/responses/bus_err=0, read_vals/mem_addr/mem_write_val=0, round-robin pointer favours the data port.
REQ-020 Reset asserted mid-ISSUE or mid-RESP shall abort the access with no response pulse; reset has priority over all other inputs.

Verification
REQ-021 i_read_en=1, i_addr=0x10, mem_ready high the cycle after strobe, mem_read_val=0x12345678 -> mem_read_en for 1 cycle, i_response pulse at k+2, i_read_val=0x12345678.
REQ-022 i_read_en and d_write_en=1 together after reset, d_addr=0x20, d_write_val=0xCAFEF00D -> data write served first (mem_write_en, mem_addr=0x20), then instruction read; responses in separate cycles.
REQ-023 Both ports request continuously for 4 transactions -> grants alternate D,I,D,I.
REQ-024 d_read_en=1, mem_ready held 0, TIMEOUT=4 -> strobe for 4 cycles, d_read_val=0xEEEEEEEE, d_response pulse, bus_err=1 and stays 1 until reset.
REQ-025 reset=1 during ISSUE of a read -> next cycle all strobes 0, no response pulse, state IDLE, new request served normally.
REQ-026 d_read_en=1 and d_write_en=1 -> only mem_write_en asserted, d_read_val unchanged.
